// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: display-bus observation interface.
// Ports:
//   seg_n       - active-low segments, bit0=a .. bit6=g
//   an_n        - active-low digit enables
//   hex_out     - decoded nibbles, digit i at [4i+3:4i]
//   digit_valid - per-digit legal decode flag
//   digit_blank - per-digit all-segments-off flag
//   frame_valid - pulse when every digit has been committed
//   err         - pulse on an illegal pattern or a multi-digit enable
interface seg7_scan_decoder_if #(parameter int NUM_DIGITS = 4);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic                    frame_valid;
    logic                    err;
    modport master(output seg_n, an_n, input hex_out, digit_valid, digit_blank, frame_valid, err);
    modport slave(input seg_n, an_n, output hex_out, digit_valid, digit_blank, frame_valid, err);
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds hex nibbles from a multiplexed active-low 7-segment bus.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - seg7_scan_decoder_if slave (seg_n/an_n in; hex_out, digit_valid,
//           digit_blank, frame_valid, err out)
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic           clk,
    input logic           reset,
    seg7_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NUM_DIGITS + 7;
    // Segment patterns for nibbles F..0, entry k at [7k+6:7k].
    localparam logic [16*7-1:0] PAT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    typedef enum logic {SETTLE, LOCKED} state_t;
    state_t                  st;
    logic [SW-1:0]           smp, cur;
    logic [CW-1:0]           cnt;
    logic [NUM_DIGITS-1:0]   seen, lo, cmask, dv, db;
    logic [4*NUM_DIGITS-1:0] hex;
    logic                    fv, er, same, commit, one, hit, blank, bad;
    logic [3:0]              nib;
    always_comb begin
        cur    = {bus.an_n, bus.seg_n};
        same   = cur == smp;
        // The commit edge is the one that would bring the count to STABLE_CYCLES.
        commit = same && st == SETTLE && cnt == CW'(STABLE_CYCLES - 1);
        lo     = ~bus.an_n;
        one    = lo != '0 && (lo & (lo - NUM_DIGITS'(1))) == '0;
        hit    = 1'b0;
        nib    = 4'd0;
        for (int k = 0; k < 16; k++)
            if (bus.seg_n == PAT[k*7 +: 7]) begin
                hit = 1'b1;
                nib = 4'(k);
            end
        blank  = bus.seg_n == 7'h7F;
        cmask  = (commit && one) ? lo : '0;
        // All-ones enables is inter-digit blanking and never an error.
        bad    = commit && lo != '0 && (!one || (!hit && !blank));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            smp  <= '1;
            cnt  <= '0;
            st   <= SETTLE;
            seen <= '0;
            hex  <= '0;
            dv   <= '0;
            db   <= '0;
            fv   <= 1'b0;
            er   <= 1'b0;
        end else begin
            smp  <= cur;
            cnt  <= !same ? '0 : (cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1));
            st   <= !same ? SETTLE : (commit ? LOCKED : st);
            er   <= bad;
            fv   <= seen == '1;
            // A commit on the frame edge lands in the freshly cleared mask.
            seen <= (seen == '1 ? '0 : seen) | cmask;
            for (int i = 0; i < NUM_DIGITS; i++)
                if (cmask[i]) begin
                    if (hit) hex[4*i +: 4] <= nib;
                    dv[i] <= hit;
                    db[i] <= !hit && blank;
                end
        end
    end
    assign bus.hex_out     = hex;
    assign bus.digit_valid = dv;
    assign bus.digit_blank = db;
    assign bus.frame_valid = fv;
    assign bus.err         = er;
endmodule
